sync_ctrl: RTL
==============

// Module: sync_ctrl
// PURPOSE
//   Controller for the axis_synchronizer circular sample buffer. Drives the BRAM write and read
//   address counter (wea/reb/addrb_load_en/addrb_load) and finds the frame start as the
//   correlation-metric peak. Streams FRAME_LEN buffered samples from the peak onward to the
//   downstream demodulator over AXI-Stream.
// PARAMETERS
//   ADDR_W       13    buffer address width (depth 2^ADDR_W)
//   DATA_W       32    sample width on doutb / m_axis_tdata
//   METRIC_W     32    unsigned correlation metric width
//   PEAK_WIN     64    samples searched for the maximum, counting the threshold-crossing sample
//   FRAME_LEN    2560  samples streamed per detected frame; PEAK_WIN+FRAME_LEN < 2^ADDR_W
//   START_OFFSET 0     added to the peak address before the read pointer is loaded
// PORTS
//   clk            in   1         clock
//   rst_n          in   1         reset, asynchronous, active-low
//   s_axis_tvalid  in   1         input sample valid; sample data goes straight to BRAM port A
//   s_axis_tready  out  1         constant 1 out of reset; the buffer is circular
//   metric_in      in   METRIC_W  correlation metric aligned with the s_axis sample
//   threshold      in   METRIC_W  detection threshold, quasi-static
//   wea            out  1         write strobe to address counter / BRAM A
//   addra          in   ADDR_W    address the current s_axis sample is written to
//   reb            out  1         read strobe; address counter post-increments addrb
//   addrb_load_en  out  1         load read pointer
//   addrb_load     out  ADDR_W    read pointer load value
//   doutb          in   DATA_W    BRAM port-B data, valid 1 cycle after reb
//   m_axis_tdata   out  DATA_W    output sample
//   m_axis_tvalid  out  1         output valid
//   m_axis_tready  in   1         downstream ready
//   m_axis_tlast   out  1         high on the FRAME_LEN-th sample
//   frame_det      out  1         1-cycle pulse in LOAD
//   busy           out  1         state != IDLE
// BEHAVIOUR
//   Reset: all outputs 0, except s_axis_tready, which is 0 during reset and 1 after.
//     State IDLE; counters, peak registers and output FIFO cleared.
//     An asynchronous reset mid-frame aborts immediately. No partial tlast is emitted.
//   wea = s_axis_tvalid & s_axis_tready. Writes continue in every state.
//   States:
//     IDLE  : on a valid sample with metric_in > threshold, set peak_val=metric_in,
//             peak_addr=addra, win_cnt=1, and go to PEAK.
//             If PEAK_WIN==1, go straight to LOAD.
//     PEAK  : on each valid sample, if metric_in > peak_val (strict; earliest peak wins ties),
//             update peak_val/peak_addr. Increment win_cnt.
//             When win_cnt reaches PEAK_WIN, go to LOAD next cycle.
//             Cycles without valid samples do not count.
//     LOAD  : 1 cycle. Assert addrb_load_en with addrb_load = peak_addr+START_OFFSET mod 2^ADDR_W.
//             Pulse frame_det. Clear rd_cnt. Go to READ.
//     READ  : assert reb while rd_cnt < FRAME_LEN and fifo_cnt + inflight - pop < 2,
//             where pop = m_axis_tvalid & m_axis_tready. Each reb increments rd_cnt.
//             doutb is captured into the 2-entry output FIFO one cycle after reb.
//             At rd_cnt == FRAME_LEN, go to DRAIN.
//     DRAIN : wait until the FIFO is empty and nothing is in flight, then go to IDLE.
//   Threshold crossings outside IDLE are ignored. Detection re-arms only on samples that
//     arrive after returning to IDLE.
//   Throughput: with m_axis_tready held 1, one sample per cycle. First tvalid 3 cycles after LOAD.
//   Backpressure: tvalid is held until accepted. tdata/tlast are stable while tvalid & !tready.
//     No sample is lost or duplicated.
//   tlast: an output-side counter asserts it on the FRAME_LEN-th accepted word.
//   Wrap-around: every address is modulo 2^ADDR_W. Reads may cross 8191 -> 0.
// STRUCTURE
//   sync_pkg: state enum (IDLE, PEAK, LOAD, READ, DRAIN) and default widths.
//   Sub-module sync_out_fifo: 2-entry registered FIFO giving the credit count, with
//     fifo_cnt/push/pop interface.
//   addr_counter is instantiated beside this block at the synchronizer top, not inside it.
// TESTING
//   1. threshold=100; metric 0 except 150 at addra=10 and 400 at addra=40 (window 64)
//      -> addrb_load=40, frame_det once, 2560 beats, tlast on beat 2560 only.
//   2. Equal peaks of 300 at addra=20 and 50 -> addrb_load=20 (earliest wins).
//   3. Peak at addra=8190, START_OFFSET=5 -> addrb_load=3; data read across the wrap
//      matches the written ramp.
//   4. m_axis_tready random at 30% -> output sequence identical to case 1.
//      tdata stable during stalls, no gaps in rd order.
//   5. rst_n low for 1 cycle mid-READ -> all outputs 0 immediately; idle after release.
//      The next crossing triggers a fresh frame.
//   6. Crossing during READ/DRAIN -> ignored. Crossing 1 sample after DRAIN ends -> second frame.

Source files
------------

// File: rtl/sync_pkg.sv
// Shared state encoding, default widths and the output-credit helper for sync_ctrl.
package sync_pkg;

    localparam int ADDR_W_DEF    = 13;
    localparam int DATA_W_DEF    = 32;
    localparam int METRIC_W_DEF  = 32;
    localparam int PEAK_WIN_DEF  = 64;
    localparam int FRAME_LEN_DEF = 2560;

    localparam int STATE_W = 3;

    // Controller states, kept as plain constants so older tools can read them.
    localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] S_PEAK  = 3'd1;
    localparam logic [STATE_W-1:0] S_LOAD  = 3'd2;
    localparam logic [STATE_W-1:0] S_READ  = 3'd3;
    localparam logic [STATE_W-1:0] S_DRAIN = 3'd4;

    // A new read may be issued only while the words already held or on their way
    // from the BRAM, less the word leaving this cycle, leave room in the 2-deep FIFO.
    function automatic logic has_credit(input logic [1:0] fifo_cnt,
                                        input logic       inflight,
                                        input logic       pop);
        logic [2:0] occ;
        occ = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
        return occ < 3'd2;
    endfunction

endpackage

// File: rtl/sync_out_fifo.sv
// Two-entry registered output FIFO; its count is the read-credit source for sync_ctrl.
module sync_out_fifo #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [1:0]        fifo_cnt
);

    logic [DATA_W-1:0] tail_data;

    // Head always holds the oldest word; a pop shifts the tail forward.
    // The caller never pushes into a full FIFO nor pops an empty one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_data <= '0;
            tail_data <= '0;
            fifo_cnt  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (fifo_cnt == 2'd0) head_data <= push_data;
                    else                  tail_data <= push_data;
                    fifo_cnt <= fifo_cnt + 2'd1;
                end
                2'b01: begin
                    head_data <= tail_data;
                    fifo_cnt  <= fifo_cnt - 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt == 2'd1) begin
                        head_data <= push_data;
                    end else begin
                        head_data <= tail_data;
                        tail_data <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sync_ctrl.sv
// Frame-sync controller: finds the correlation peak in a window after a threshold
// crossing, loads the BRAM read pointer there and streams FRAME_LEN samples out.
module sync_ctrl
    import sync_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int METRIC_W     = METRIC_W_DEF,
    parameter int PEAK_WIN     = PEAK_WIN_DEF,
    parameter int FRAME_LEN    = FRAME_LEN_DEF,
    parameter int START_OFFSET = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic [METRIC_W-1:0] metric_in,
    input  logic [METRIC_W-1:0] threshold,
    output logic                wea,
    input  logic [ADDR_W-1:0]   addra,
    output logic                reb,
    output logic                addrb_load_en,
    output logic [ADDR_W-1:0]   addrb_load,
    input  logic [DATA_W-1:0]   doutb,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast,
    output logic                frame_det,
    output logic                busy
);

    // Streams: a word moves on either AXI-Stream side only in a cycle where both
    // tvalid and tready are high; tvalid, tdata and tlast hold until that happens.

    localparam int WIN_W = $clog2(PEAK_WIN + 1);
    localparam int RD_W  = $clog2(FRAME_LEN + 1);

    localparam logic [WIN_W-1:0]  WIN_LAST_PREV = WIN_W'(PEAK_WIN - 1);
    localparam logic [RD_W-1:0]   RD_DONE       = RD_W'(FRAME_LEN);
    localparam logic [RD_W-1:0]   OUT_LAST      = RD_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] OFFSET        = ADDR_W'(START_OFFSET);

    logic [STATE_W-1:0]  state;
    logic [STATE_W-1:0]  state_nxt;
    logic                ready_q;
    logic [METRIC_W-1:0] peak_val;
    logic [ADDR_W-1:0]   peak_addr;
    logic [WIN_W-1:0]    win_cnt;
    logic [RD_W-1:0]     rd_cnt;
    logic [RD_W-1:0]     out_cnt;
    logic                inflight;
    logic [1:0]          fifo_cnt;
    logic                hit;
    logic                pop;

    assign s_axis_tready = ready_q;
    assign wea           = s_axis_tvalid & ready_q;
    assign hit           = wea && (metric_in > threshold);

    assign m_axis_tvalid = (fifo_cnt != 2'd0);
    assign pop           = m_axis_tvalid & m_axis_tready;
    assign m_axis_tlast  = m_axis_tvalid && (out_cnt == OUT_LAST);

    assign reb = (state == S_READ) && (rd_cnt < RD_DONE) &&
                 has_credit(fifo_cnt, inflight, pop);

    assign addrb_load_en = (state == S_LOAD);
    assign addrb_load    = (state == S_LOAD) ? (peak_addr + OFFSET) : '0;
    assign frame_det     = (state == S_LOAD);
    assign busy          = (state != S_IDLE);

    // The input side is circular and never stalls; ready only drops in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_q <= 1'b0;
        else        ready_q <= 1'b1;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; only IDLE looks at the threshold, so crossings elsewhere are ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (hit) state_nxt = (PEAK_WIN == 1) ? S_LOAD : S_PEAK;
            S_PEAK:  if (wea && (win_cnt == WIN_LAST_PREV)) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_READ;
            S_READ:  if (rd_cnt == RD_DONE) state_nxt = S_DRAIN;
            S_DRAIN: if ((fifo_cnt == 2'd0) && !inflight) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Peak search over the window; strict compare keeps the earliest of equal peaks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_val  <= '0;
            peak_addr <= '0;
            win_cnt   <= '0;
        end else if (state == S_IDLE) begin
            if (hit) begin
                peak_val  <= metric_in;
                peak_addr <= addra;
                win_cnt   <= WIN_W'(1);
            end
        end else if ((state == S_PEAK) && wea) begin
            win_cnt <= win_cnt + WIN_W'(1);
            if (metric_in > peak_val) begin
                peak_val  <= metric_in;
                peak_addr <= addra;
            end
        end
    end

    // Read-side bookkeeping: words requested this frame and the one-cycle BRAM latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= reb;
            if (state == S_LOAD) rd_cnt <= '0;
            else if (reb)        rd_cnt <= rd_cnt + RD_W'(1);
        end
    end

    // Output-side beat counter that places tlast on the last accepted word of the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt <= '0;
        end else if (state == S_LOAD) begin
            out_cnt <= '0;
        end else if (pop) begin
            out_cnt <= m_axis_tlast ? '0 : out_cnt + RD_W'(1);
        end
    end

    sync_out_fifo #(
        .DATA_W (DATA_W)
    ) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (doutb),
        .pop       (pop),
        .head_data (m_axis_tdata),
        .fifo_cnt  (fifo_cnt)
    );

endmodule
